// File: rtl/vga_timing_gen.sv
// Programmable VGA sync/timing generator with a built-in pixel-clock divider.
// Define VGA_ADDR_EN to add the linear frame-buffer address output oColorAddress.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 2,
    parameter int   X_W      = 10,
    parameter int   Y_W      = 10,
    parameter int   ADDR_W   = 19
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic             oHs,
    output logic             oVs,
    output logic             oActive,
    output logic [X_W-1:0]   oX,
    output logic [Y_W-1:0]   oY,
    output logic             oPixelTick,
    output logic             oLineStart,
    output logic             oFrameStart
`ifdef VGA_ADDR_EN
    ,
    output logic [ADDR_W-1:0] oColorAddress
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam bit BAD_PARAMS = (H_TOTAL > (1 << X_W)) || (V_TOTAL > (1 << Y_W)) ||
                                (CLK_DIV < 1) || (ADDR_W < 1) ||
                                (H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
                                (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1);

    generate
        if (BAD_PARAMS) begin : g_bad_params
            $error("vga_timing_gen: illegal timing/width parameters");
        end
    endgenerate

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]   HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             run_q,  run_d;
    logic [DIV_W-1:0] div_q,  div_d;
    logic [X_W-1:0]   hcnt_q, hcnt_d;
    logic [Y_W-1:0]   vcnt_q, vcnt_d;

    logic tick, line_end, frame_end, active, hs_on, vs_on, line_start;

    always_comb begin
        tick      = run_q && (div_q == DIV_LAST);
        line_end  = (hcnt_q == H_LAST);
        frame_end = line_end && (vcnt_q == V_LAST);

        run_d  = 1'b1;
        div_d  = div_q;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;

        // Counters stay frozen until run is set so the first run cycle is pixel (0,0), div 0.
        if (run_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            if (line_end) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end

        if (Reset) begin
            run_d  = 1'b0;
            div_d  = '0;
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        run_q  <= run_d;
        div_q  <= div_d;
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
    end

    always_comb begin
        active     = run_q && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_on      = run_q && (hcnt_q >= HS_START) && (hcnt_q < HS_END);
        vs_on      = run_q && (vcnt_q >= VS_START) && (vcnt_q < VS_END);
        line_start = run_q && (hcnt_q == '0) && (div_q == '0);
    end

    assign oX          = hcnt_q;
    assign oY          = vcnt_q;
    assign oActive     = active;
    assign oHs         = hs_on ? HS_POL : ~HS_POL;
    assign oVs         = vs_on ? VS_POL : ~VS_POL;
    assign oPixelTick  = tick;
    assign oLineStart  = line_start;
    assign oFrameStart = line_start && (vcnt_q == '0);

`ifdef VGA_ADDR_EN
    // Running address tracks oY*H_ACTIVE+oX by counting visible pixels, avoiding a multiplier.
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (tick) begin
            if (frame_end) begin
                addr_d = '0;
            end else if (active) begin
                addr_d = addr_q + 1'b1;
            end
        end
        if (Reset) begin
            addr_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        addr_q <= addr_d;
    end

    assign oColorAddress = addr_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen on a tiny 8x6 raster.
// Three instances share Clock/Reset: CLK_DIV=2 pol 0, CLK_DIV=2 pol 1, CLK_DIV=1 pol 0.
module tb_vga_timing_gen;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 Clock = ~Clock;

    logic       hs0, vs0, act0, tick0, ls0, fs0;
    logic       hsp, vsp, actp, tickp, lsp, fsp;
    logic       hsd, vsd, actd, tickd, lsd, fsd;
    logic [9:0] x0, y0, xp, yp, xd, yd;
`ifdef VGA_ADDR_EN
    logic [7:0] addr0, addrp, addrd;
`endif

    logic [5:0] f0, fp, fd;
    assign f0 = {hs0, vs0, act0, tick0, ls0, fs0};
    assign fp = {hsp, vsp, actp, tickp, lsp, fsp};
    assign fd = {hsd, vsd, actd, tickd, lsd, fsd};

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2),
        .X_W(10), .Y_W(10), .ADDR_W(8)
    ) dut (
`ifdef VGA_ADDR_EN
        .oColorAddress(addr0),
`endif
        .Clock(Clock), .Reset(Reset), .oHs(hs0), .oVs(vs0), .oActive(act0),
        .oX(x0), .oY(y0), .oPixelTick(tick0), .oLineStart(ls0), .oFrameStart(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(2),
        .X_W(10), .Y_W(10), .ADDR_W(8)
    ) dut_pol (
`ifdef VGA_ADDR_EN
        .oColorAddress(addrp),
`endif
        .Clock(Clock), .Reset(Reset), .oHs(hsp), .oVs(vsp), .oActive(actp),
        .oX(xp), .oY(yp), .oPixelTick(tickp), .oLineStart(lsp), .oFrameStart(fsp)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1),
        .X_W(10), .Y_W(10), .ADDR_W(8)
    ) dut_div1 (
`ifdef VGA_ADDR_EN
        .oColorAddress(addrd),
`endif
        .Clock(Clock), .Reset(Reset), .oHs(hsd), .oVs(vsd), .oActive(actd),
        .oX(xd), .oY(yd), .oPixelTick(tickd), .oLineStart(lsd), .oFrameStart(fsd)
    );

    // Expected {hs,vs,active,tick,linestart,framestart} at run clock c, CLK_DIV=2, pol 0.
    function automatic logic [5:0] exp_div2(input int c);
        int l;
        l = c % 16;
        exp_div2 = {!(l >= 10 && l <= 13), !((c % 96) >= 64 && (c % 96) <= 79),
                    (l < 8) && (((c % 96) / 16) < 3), (c % 2) == 1,
                    l == 0, (c % 96) == 0};
    endfunction

    // Same for CLK_DIV=1: one pixel per clock, 8 clocks per line.
    function automatic logic [5:0] exp_div1(input int c);
        int h;
        int v;
        h = c % 8;
        v = (c / 8) % 6;
        exp_div1 = {!(h == 5 || h == 6), !(v == 4), (h < 4) && (v < 3), 1'b1,
                    h == 0, (c % 48) == 0};
    endfunction

    // Hold reset for three edges, release, and land on the first run clock (c = 0).
    task automatic start_run();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (f0 !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags_pol0 got %b want %b", f0, 6'b110000);
        end
        checks++;
        if (fp !== 6'b000000) begin
            errors++;
            $display("FAIL reset_flags_pol1 got %b want %b", fp, 6'b000000);
        end
        checks++;
        if (x0 !== 10'd0 || y0 !== 10'd0) begin
            errors++;
            $display("FAIL reset_xy got %0d,%0d want 0,0", x0, y0);
        end
        Reset = 1'b0;
        step();
        checks++;
        if (f0 !== 6'b111011 || x0 !== 10'd0 || y0 !== 10'd0) begin
            errors++;
            $display("FAIL first_run_cycle got flags %b xy %0d,%0d want flags %b xy 0,0",
                     f0, x0, y0, 6'b111011);
        end
    endtask

    task automatic test_sync_timing();
        start_run();
        for (int c = 0; c < 192; c++) begin
            checks++;
            if (f0 !== exp_div2(c)) begin
                errors++;
                $display("FAIL sync_flags c=%0d got %b want %b", c, f0, exp_div2(c));
            end
            checks++;
            if (x0 !== 10'((c / 2) % 8) || y0 !== 10'((c / 16) % 6)) begin
                errors++;
                $display("FAIL sync_xy c=%0d got %0d,%0d want %0d,%0d", c, x0, y0,
                         (c / 2) % 8, (c / 16) % 6);
            end
            step();
        end
    endtask

    task automatic test_active_vsync();
        int act_n;
        int vs_low_n;
        int act_late;
        act_n = 0;
        vs_low_n = 0;
        act_late = 0;
        start_run();
        for (int c = 0; c < 96; c++) begin
            if (act0 === 1'b1) act_n++;
            if (act0 === 1'b1 && c >= 48) act_late++;
            if (vs0 === 1'b0) vs_low_n++;
            step();
        end
        checks++;
        if (act_n != 24) begin
            errors++;
            $display("FAIL active_count got %0d want 24", act_n);
        end
        checks++;
        if (act_late != 0) begin
            errors++;
            $display("FAIL active_in_blank_lines got %0d want 0", act_late);
        end
        checks++;
        if (vs_low_n != 16) begin
            errors++;
            $display("FAIL vsync_low_count got %0d want 16", vs_low_n);
        end
    endtask

    task automatic test_polarity();
        start_run();
        for (int c = 0; c < 192; c++) begin
            checks++;
            if (fp !== (exp_div2(c) ^ 6'b110000) || xp !== 10'((c / 2) % 8) ||
                yp !== 10'((c / 16) % 6)) begin
                errors++;
                $display("FAIL polarity c=%0d got %b xy %0d,%0d want %b", c, fp, xp, yp,
                         exp_div2(c) ^ 6'b110000);
            end
            step();
        end
    endtask

    task automatic test_clk_div1();
        start_run();
        for (int c = 0; c < 96; c++) begin
            checks++;
            if (fd !== exp_div1(c) || xd !== 10'(c % 8) || yd !== 10'((c / 8) % 6)) begin
                errors++;
                $display("FAIL clk_div1 c=%0d got %b xy %0d,%0d want %b xy %0d,%0d", c, fd,
                         xd, yd, exp_div1(c), c % 8, (c / 8) % 6);
            end
            step();
        end
    endtask

    task automatic test_mid_frame_reset();
        start_run();
        repeat (42) step();
        checks++;
        if (x0 !== 10'd5 || y0 !== 10'd2) begin
            errors++;
            $display("FAIL midreset_position got %0d,%0d want 5,2", x0, y0);
        end
        Reset = 1'b1;
        step();
        checks++;
        if (f0 !== 6'b110000 || x0 !== 10'd0 || y0 !== 10'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %b xy %0d,%0d want %b xy 0,0", f0, x0, y0,
                     6'b110000);
        end
        Reset = 1'b0;
        step();
        checks++;
        if (f0 !== 6'b111011 || x0 !== 10'd0 || y0 !== 10'd0) begin
            errors++;
            $display("FAIL midreset_restart got %b xy %0d,%0d want %b xy 0,0", f0, x0, y0,
                     6'b111011);
        end
        repeat (95) step();
        checks++;
        if (fs0 !== 1'b0) begin
            errors++;
            $display("FAIL frame_period_early got %b want 0", fs0);
        end
        step();
        checks++;
        if (fs0 !== 1'b1) begin
            errors++;
            $display("FAIL frame_period got %b want 1", fs0);
        end
    endtask

`ifdef VGA_ADDR_EN
    task automatic test_color_address();
        int h;
        int v;
        int e;
        start_run();
        for (int c = 0; c < 192; c++) begin
            h = (c / 2) % 8;
            v = (c / 16) % 6;
            if (h < 4 && v < 3) e = v * 4 + h;
            else if (v < 3) e = v * 4 + 4;
            else e = 12;
            checks++;
            if (addr0 !== 8'(e)) begin
                errors++;
                $display("FAIL color_address c=%0d xy %0d,%0d got %0d want %0d", c, h, v,
                         addr0, e);
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sync_timing();
        test_active_vsync();
        test_polarity();
        test_clk_div1();
        test_mid_frame_reset();
`ifdef VGA_ADDR_EN
        test_color_address();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA sync/timing generator; next generation of the fixed-count sync block.
- Programmable front porch, sync, back porch and polarity per axis; built-in pixel-clock divider.
- Outputs pixel coordinates, active-video flag and line/frame strobes.
- Sits between the system clock and the pixel/colour path; drives the monitor's Hs/Vs pins and the frame-buffer read address.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of oHs
VS_POL, 0, active level of oVs
CLK_DIV, 2, Clock cycles per pixel (>=1)
X_W, 10, width of oX; must hold H_TOTAL-1
Y_W, 10, width of oY; must hold V_TOTAL-1
ADDR_W, 19, width of oColorAddress

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
oHs  out  1  horizontal sync, level per HS_POL
oVs  out  1  vertical sync, level per VS_POL
oActive  out  1  high while the current pixel is visible
oX  out  X_W  horizontal counter (pixel column)
oY  out  Y_W  vertical counter (line)
oPixelTick  out  1  one-Clock pulse on the last Clock of each pixel
oLineStart  out  1  one-Clock pulse on the first Clock of pixel 0 of every line
oFrameStart  out  1  one-Clock pulse on the first Clock of pixel (0,0)
oColorAddress  out  ADDR_W  linear frame-buffer address (only with VGA_ADDR_EN)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Registers: div (0..CLK_DIV-1), hcnt, vcnt, run.
- Reset, synchronous: div=0, hcnt=0, vcnt=0, run=0.
- While run=0: oHs=~HS_POL, oVs=~VS_POL; oActive, oPixelTick, oLineStart and oFrameStart are 0; oX=0, oY=0.
- run is set on the first edge with Reset low. Counters hold until run=1, so the first Clock with run=1 shows pixel (0,0) with div=0.
- Pixel tick:
  - tick = run && div==CLK_DIV-1.
  - div increments each run cycle and wraps to 0 on tick.
  - CLK_DIV=1 gives tick every cycle while run=1.
- On tick:
  - If hcnt==H_TOTAL-1: hcnt=0, and vcnt = (vcnt==V_TOTAL-1) ? 0 : vcnt+1.
  - Otherwise: hcnt+1.
- All outputs are decoded from the current register values, zero skew between coordinates and flags:
  - oX=hcnt, oY=vcnt.
  - oActive = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - oHs = HS_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - oVs = VS_POL when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. oVs changes only at line boundaries.
  - oLineStart = run && hcnt==0 && div==0.
  - oFrameStart = oLineStart && vcnt==0.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV Clocks, exactly, with no drift.
- Reset mid-frame: on the next edge all registers clear and outputs go to reset values; timing restarts from (0,0) after release.
- Bad parameters are an elaboration error: H_TOTAL > 2^X_W, V_TOTAL > 2^Y_W, CLK_DIV=0, or any porch/sync value of 0.

Optional Feature:
- Macro: VGA_ADDR_EN.
- Defined:
  - oColorAddress port exists, backed by an address register cleared by Reset.
  - Cleared on any tick that takes hcnt,vcnt to (0,0).
  - Incremented on each tick while oActive=1; holds otherwise.
  - Invariant: oColorAddress = oY*H_ACTIVE+oX whenever oActive=1. No multiplier is used.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Sim parameters for all tests: H=4/1/2/1 (H_TOTAL 8), V=3/1/1/1 (V_TOTAL 6), CLK_DIV=2, pol 0.
- Test 1: Reset 3 cycles, release -> first run cycle has oFrameStart=1, oLineStart=1, oActive=1, oX=0, oY=0; oHs low for Clocks 10..13 after run; oLineStart every 16 Clocks; oFrameStart every 96 Clocks.
- Test 2: Same run -> oActive high for 8 of every 16 Clocks in lines 0..2, 0 in lines 3..5; oVs low exactly for line 4 (Clocks 64..79 of the frame).
- Test 3: HS_POL=1, VS_POL=1 -> sync outputs inverted, idle level 0 during Reset; all counts as in Test 1.
- Test 4: CLK_DIV=1 -> oPixelTick constantly 1 after run; frame period 48 Clocks; oX sequence 0..7 wraps.
- Test 5: Assert Reset at oX=5, oY=2 for 1 cycle -> next edge outputs at reset values; after release, oFrameStart occurs on the first run cycle.
- Test 6: VGA_ADDR_EN defined -> oColorAddress = 0 at (0,0), 6 at (2,1), 11 at (3,2); holds 12 through blanking; returns to 0 at next oFrameStart.
